// File: rtl/pmp_region_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pmp_pkg
// Brief    : Shared PMP types: region mode encoding, config and request records.
// Revision : 1.0
// ============================================================================
package pmp_pkg;

    localparam int unsigned PMP_ADDR_W = 34;

    typedef enum logic [1:0] {
        OFF   = 2'b00,
        TOR   = 2'b01,
        NA4   = 2'b10,
        NAPOT = 2'b11
    } pmp_cfg_mode_e;

    typedef struct packed {
        logic          lock;
        pmp_cfg_mode_e mode;
        logic          w;
        logic          r;
    } pmp_cfg_t;

    typedef struct packed {
        logic [PMP_ADDR_W-1:0] addr;
        logic                  wr;
    } pmp_req_t;

endpackage
`default_nettype wire

// File: rtl/pmp_region_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : pmp_region_checker_if
// Brief    : CSR write, request and verdict signals of the PMP checker.
// Revision : 1.0
// ============================================================================
interface pmp_region_checker_if
    import pmp_pkg::*;
#(
    parameter int unsigned NUM_REGIONS = 4,
    parameter int unsigned NUM_CHAN    = 2,
    parameter int unsigned ADDR_W      = 34,
    parameter int unsigned CNT_W       = 16
);
    localparam int unsigned c_idx_w = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int unsigned c_rgn_w = $clog2(NUM_REGIONS + 1);

    logic                                cfg_we_i;
    logic [c_idx_w-1:0]                  cfg_idx_i;
    pmp_cfg_t                            cfg_wdata_i;
    logic                                addr_we_i;
    logic [c_idx_w-1:0]                  addr_idx_i;
    logic [ADDR_W-3:0]                   addr_wdata_i;
    logic [NUM_CHAN-1:0]                 req_valid_i;
    logic [NUM_CHAN-1:0][ADDR_W-1:0]     req_addr_i;
    logic [NUM_CHAN-1:0]                 req_wr_i;
    logic [NUM_CHAN-1:0]                 rsp_valid_o;
    logic [NUM_CHAN-1:0]                 rsp_err_o;
    logic [NUM_CHAN-1:0][c_rgn_w-1:0]    rsp_region_o;
    logic [NUM_CHAN-1:0][CNT_W-1:0]      deny_cnt_o;
    logic                                cnt_clr_i;

    modport master (
        output cfg_we_i, cfg_idx_i, cfg_wdata_i,
        output addr_we_i, addr_idx_i, addr_wdata_i,
        output req_valid_i, req_addr_i, req_wr_i, cnt_clr_i,
        input  rsp_valid_o, rsp_err_o, rsp_region_o, deny_cnt_o
    );

    modport slave (
        input  cfg_we_i, cfg_idx_i, cfg_wdata_i,
        input  addr_we_i, addr_idx_i, addr_wdata_i,
        input  req_valid_i, req_addr_i, req_wr_i, cnt_clr_i,
        output rsp_valid_o, rsp_err_o, rsp_region_o, deny_cnt_o
    );

endinterface
`default_nettype wire

// File: rtl/pmp_region_checker_match.sv
`default_nettype none
// ============================================================================
// Module   : pmp_match
// Brief    : Combinational single-region address matcher (OFF/TOR/NA4/NAPOT).
// Revision : 1.0
// ============================================================================
module pmp_match
    import pmp_pkg::*;
#(
    parameter int unsigned AW = 32
) (
    input  pmp_cfg_mode_e   i_mode,
    input  logic [AW-1:0]   i_addr,
    input  logic [AW-1:0]   i_prev_addr,
    input  logic [AW-1:0]   i_req_addr,
    output logic            o_hit
);
    logic [AW-1:0] w_napot_mask;

    // Mask covers the trailing ones of the region address plus the first zero.
    assign w_napot_mask = i_addr ^ (i_addr + 1'b1);

    always_comb begin
        o_hit = 1'b0;
        case (i_mode)
            OFF:     o_hit = 1'b0;
            TOR:     o_hit = (i_prev_addr < i_addr) &&
                             (i_req_addr >= i_prev_addr) &&
                             (i_req_addr < i_addr);
            NA4:     o_hit = (i_req_addr == i_addr);
            NAPOT:   o_hit = ((i_req_addr | w_napot_mask) == (i_addr | w_napot_mask));
            default: o_hit = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pmp_region_checker.sv
`default_nettype none
// ============================================================================
// Module   : pmp_region_checker
// Brief    : PMP register file with lock rules and per-channel registered verdicts.
// Revision : 1.0
// ============================================================================
module pmp_region_checker
    import pmp_pkg::*;
#(
    parameter int unsigned NUM_REGIONS   = 4,
    parameter int unsigned NUM_CHAN      = 2,
    parameter int unsigned ADDR_W        = 34,
    parameter int unsigned CNT_W         = 16,
    parameter bit          DEFAULT_ALLOW = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    pmp_region_checker_if.slave    bus_if
);
    localparam int unsigned c_idx_w = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int unsigned c_rgn_w = $clog2(NUM_REGIONS + 1);
    localparam int unsigned c_aw    = ADDR_W - 2;
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    pmp_cfg_t [NUM_REGIONS-1:0]              r_cfg;
    logic     [NUM_REGIONS-1:0][c_aw-1:0]    r_addr;

    logic [NUM_REGIONS-1:0]                  w_tor_lock;
    logic [NUM_REGIONS-1:0]                  w_tor_lock_above;
    logic [NUM_REGIONS-1:0]                  w_cfg_wr_en;
    logic [NUM_REGIONS-1:0]                  w_addr_wr_en;

    logic [NUM_CHAN-1:0][NUM_REGIONS-1:0]    w_hit;
    logic [NUM_CHAN-1:0]                     w_err;
    logic [NUM_CHAN-1:0][c_rgn_w-1:0]        w_region;

    logic [NUM_CHAN-1:0]                     r_rsp_valid;
    logic [NUM_CHAN-1:0]                     r_rsp_err;
    logic [NUM_CHAN-1:0][c_rgn_w-1:0]        r_rsp_region;
    logic [NUM_CHAN-1:0][CNT_W-1:0]          r_deny_cnt;

    // A locked TOR region also freezes the address below it (its lower bound).
    always_comb begin
        for (int i = 0; i < NUM_REGIONS; i++) begin
            w_tor_lock[i] = r_cfg[i].lock && (r_cfg[i].mode == TOR);
        end
        w_tor_lock_above = w_tor_lock >> 1;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            w_cfg_wr_en[i]  = bus_if.cfg_we_i && (bus_if.cfg_idx_i == c_idx_w'(i)) &&
                              !r_cfg[i].lock;
            w_addr_wr_en[i] = bus_if.addr_we_i && (bus_if.addr_idx_i == c_idx_w'(i)) &&
                              !r_cfg[i].lock && !w_tor_lock_above[i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cfg  <= '0;
            r_addr <= '0;
        end else begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                if (w_cfg_wr_en[i]) begin
                    r_cfg[i] <= bus_if.cfg_wdata_i;
                end
                if (w_addr_wr_en[i]) begin
                    r_addr[i] <= bus_if.addr_wdata_i;
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
        logic [1:0] w_unused_lsbs;
        assign w_unused_lsbs = bus_if.req_addr_i[c][1:0];

        for (genvar k = 0; k < NUM_REGIONS; k++) begin : g_rgn
            logic [c_aw-1:0] w_prev;
            if (k == 0) begin : g_first
                assign w_prev = '0;
            end else begin : g_rest
                assign w_prev = r_addr[k-1];
            end

            pmp_match #(
                .AW (c_aw)
            ) u_match (
                .i_mode      (r_cfg[k].mode),
                .i_addr      (r_addr[k]),
                .i_prev_addr (w_prev),
                .i_req_addr  (bus_if.req_addr_i[c][ADDR_W-1:2]),
                .o_hit       (w_hit[c][k])
            );
        end
    end

    // Scan from the top so the lowest-indexed hit wins.
    always_comb begin
        for (int c = 0; c < NUM_CHAN; c++) begin
            w_region[c] = c_rgn_w'(NUM_REGIONS);
            w_err[c]    = ~DEFAULT_ALLOW;
            for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
                if (w_hit[c][k]) begin
                    w_region[c] = c_rgn_w'(k);
                    w_err[c]    = bus_if.req_wr_i[c] ? ~r_cfg[k].w : ~r_cfg[k].r;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rsp_valid  <= '0;
            r_rsp_err    <= '0;
            r_rsp_region <= '0;
            r_deny_cnt   <= '0;
        end else begin
            for (int c = 0; c < NUM_CHAN; c++) begin
                r_rsp_valid[c]  <= bus_if.req_valid_i[c];
                r_rsp_err[c]    <= bus_if.req_valid_i[c] & w_err[c];
                r_rsp_region[c] <= bus_if.req_valid_i[c] ? w_region[c] : '0;
                if (bus_if.cnt_clr_i) begin
                    r_deny_cnt[c] <= '0;
                end else if (bus_if.req_valid_i[c] && w_err[c] &&
                             (r_deny_cnt[c] != c_cnt_max)) begin
                    r_deny_cnt[c] <= r_deny_cnt[c] + 1'b1;
                end
            end
        end
    end

    assign bus_if.rsp_valid_o  = r_rsp_valid;
    assign bus_if.rsp_err_o    = r_rsp_err;
    assign bus_if.rsp_region_o = r_rsp_region;
    assign bus_if.deny_cnt_o   = r_deny_cnt;

endmodule
`default_nettype wire
